// File: rtl/texture_mapper_legup_mult_pipe.sv
// Pipelined integer multiplier with valid/ready handshake, a pass-through tag and
// build-time or run-time operand signedness. Latency is `stages` advancing cycles.
module texture_mapper_legup_mult_pipe #(
  parameter int widtha         = 32,
  parameter int widthb         = 32,
  parameter int widthp         = 64,
  parameter     representation = "UNSIGNED",
  parameter int stages         = 2,
  parameter int tagw           = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [widtha-1:0]               dataa,
  input  logic [widthb-1:0]               datab,
  input  logic                            signa,
  input  logic                            signb,
  input  logic [tagw-1:0]                 in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [widthp-1:0]               result,
  output logic [tagw-1:0]                 out_tag,
  output logic [$clog2(stages+1)-1:0]     occupancy
);

  localparam int PW   = widtha + widthb;
  localparam int OW   = $clog2(stages + 1);
  // First stage that carries the product; with more than one stage, stage 0 holds operands.
  localparam int RES0 = (stages == 1) ? 0 : 1;

  localparam bit REP_U = (representation == "UNSIGNED");
  localparam bit REP_S = (representation == "SIGNED");
  localparam bit REP_R = (representation == "RUNTIME");

  if (!(REP_U || REP_S || REP_R)) begin : g_bad_rep
    $error("texture_mapper_legup_mult_pipe: representation must be UNSIGNED, SIGNED or RUNTIME");
  end

  logic              advance;
  logic              accept;
  logic              handshake;
  logic              sa_in;
  logic              sb_in;
  logic [PW-1:0]     ext_a;
  logic [PW-1:0]     ext_b;
  logic [PW-1:0]     mul_a;
  logic [PW-1:0]     mul_b;
  logic              mul_sx;
  logic [PW-1:0]     prod_full;
  logic [widthp-1:0] prod_res;

  logic              valid_reg [stages];
  logic [tagw-1:0]   tag_reg   [stages];
  logic [widthp-1:0] res_reg   [RES0:stages-1];
  logic [OW-1:0]     occ_reg;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign handshake = out_valid && out_ready;

  assign sa_in = REP_R ? signa : REP_S;
  assign sb_in = REP_R ? signb : REP_S;
  assign ext_a = {{widthb{sa_in & dataa[widtha-1]}}, dataa};
  assign ext_b = {{widtha{sb_in & datab[widthb-1]}}, datab};

  if (stages == 1) begin : g_comb_mul
    assign mul_a  = ext_a;
    assign mul_b  = ext_b;
    assign mul_sx = sa_in | sb_in;
  end else begin : g_reg_ops
    logic [PW-1:0] opa_reg;
    logic [PW-1:0] opb_reg;
    logic          sx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        opa_reg <= '0;
        opb_reg <= '0;
        sx_reg  <= 1'b0;
      end else if (advance) begin
        opa_reg <= ext_a;
        opb_reg <= ext_b;
        sx_reg  <= sa_in | sb_in;
      end
    end

    assign mul_a  = opa_reg;
    assign mul_b  = opb_reg;
    assign mul_sx = sx_reg;
  end

  // Both operands are already extended to PW bits, so the low PW bits are exact.
  assign prod_full = mul_a * mul_b;

  if (widthp > PW) begin : g_extend
    assign prod_res = {{(widthp - PW){mul_sx & prod_full[PW-1]}}, prod_full};
  end else begin : g_truncate
    logic unused_sx;
    assign unused_sx = mul_sx;
    assign prod_res  = prod_full[widthp-1:0];
    if (widthp < PW) begin : g_drop_hi
      logic unused_hi;
      assign unused_hi = ^prod_full[PW-1:widthp];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < stages; i++) begin
        valid_reg[i] <= 1'b0;
        tag_reg[i]   <= '0;
      end
      for (int i = RES0; i < stages; i++) begin
        res_reg[i] <= '0;
      end
      occ_reg <= '0;
    end else begin
      if (advance) begin
        valid_reg[0] <= in_valid;
        tag_reg[0]   <= in_tag;
        for (int i = 1; i < stages; i++) begin
          valid_reg[i] <= valid_reg[i-1];
          tag_reg[i]   <= tag_reg[i-1];
        end
        res_reg[RES0] <= prod_res;
        for (int i = RES0 + 1; i < stages; i++) begin
          res_reg[i] <= res_reg[i-1];
        end
      end
      if (accept && !handshake) begin
        occ_reg <= occ_reg + OW'(1);
      end else if (!accept && handshake) begin
        occ_reg <= occ_reg - OW'(1);
      end
    end
  end

  assign out_valid = valid_reg[stages-1];
  assign out_tag   = tag_reg[stages-1];
  assign result    = res_reg[stages-1];
  assign occupancy = occ_reg;

endmodule
